// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared widths, opcode names and record types for the ALU command sequencer.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;
  localparam int RES_W  = 9;

  localparam logic [SEL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [SEL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [SEL_W-1:0] ALU_MUL  = 4'b0010;
  localparam logic [SEL_W-1:0] ALU_DIV  = 4'b0011;
  localparam logic [SEL_W-1:0] ALU_SHL  = 4'b0100;
  localparam logic [SEL_W-1:0] ALU_SHR  = 4'b0101;
  localparam logic [SEL_W-1:0] ALU_ROL  = 4'b0110;
  localparam logic [SEL_W-1:0] ALU_ROR  = 4'b0111;
  localparam logic [SEL_W-1:0] ALU_AND  = 4'b1000;
  localparam logic [SEL_W-1:0] ALU_OR   = 4'b1001;
  localparam logic [SEL_W-1:0] ALU_XOR  = 4'b1010;
  localparam logic [SEL_W-1:0] ALU_NOR  = 4'b1011;
  localparam logic [SEL_W-1:0] ALU_NAND = 4'b1100;
  localparam logic [SEL_W-1:0] ALU_XNOR = 4'b1101;
  localparam logic [SEL_W-1:0] ALU_GT   = 4'b1110;
  localparam logic [SEL_W-1:0] ALU_EQ   = 4'b1111;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } seq_state_t;

  // One completed operation: the opcode that ran and its raw 9-bit result.
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [RES_W-1:0] result;
  } rsp_entry_t;

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Response FIFO for completed ALU operations. The head output holds the
// most recently popped entry while empty, so consumers never see stale RAM.
module alu_seq_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rsp_entry_t din,
  input  logic       pop,
  output rsp_entry_t dout,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  rsp_entry_t    mem [DEPTH];
  rsp_entry_t    last_q;
  logic          push_ok;
  logic          pop_ok;

  // The extra count bit makes count==DEPTH distinct from count==0.
  assign empty   = (count == '0);
  assign full    = count[AW];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? last_q : mem[rd_ptr];

  // Entry storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Remember the last entry handed out so the head holds it once empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= '0;
    else if (pop_ok) last_q <= mem[rd_ptr];
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for a combinational 8-bit ALU: accepts commands, holds operands
// for a fixed settle time, samples the result and queues it in order.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [SEL_W-1:0]  rsp_sel,
  output logic [CNT_W-1:0]  op_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [AW:0]     DEPTH_CNT   = (AW+1)'(DEPTH);

  seq_state_t      state_q;
  seq_state_t      state_d;
  logic [SC_W-1:0] settle_cnt;
  logic            accept;
  logic            settle_done;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;
  rsp_entry_t      push_entry;
  rsp_entry_t      head_entry;

  assign accept      = cmd_valid && cmd_ready;
  assign settle_done = (settle_cnt == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: one operation in flight, back to IDLE once the result is sampled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETTLE;
      SETTLE:  if (settle_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: accept only while idle with a free FIFO slot, so a push never overflows.
  always_comb begin
    cmd_ready = 1'b0;
    fifo_push = 1'b0;
    case (state_q)
      IDLE:    cmd_ready = !fifo_full;
      SETTLE:  fifo_push = settle_done;
      default: ;
    endcase
  end

  // Settle counter: loaded on accept, counts down to the sampling cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) settle_cnt <= '0;
    else if (accept) settle_cnt <= SETTLE_LOAD;
    else if ((state_q == SETTLE) && !settle_done) settle_cnt <= settle_cnt - SC_W'(1);
  end

  // Operand registers feeding the ALU; held after capture until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (accept) begin
      alu_a   <= cmd_a;
      alu_b   <= cmd_b;
      alu_sel <= cmd_sel;
    end
  end

  // Completed-operation counter, wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count <= '0;
    else if (fifo_push) op_count <= op_count + CNT_W'(1);
  end

  assign push_entry.sel    = alu_sel;
  assign push_entry.result = alu_result;
  assign fifo_pop          = rsp_valid && rsp_ready;
  assign rsp_valid         = !fifo_empty;
  assign rsp_result        = head_entry.result;
  assign rsp_sel           = head_entry.sel;

  alu_seq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (push_entry),
    .pop  (fifo_pop),
    .dout (head_entry),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // A push into a full FIFO would drop a result; the accept gating rules it out.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    fifo_push |-> ((fifo_count != DEPTH_CNT) || fifo_pop));

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer driving a behavioural stand-in for the ALU.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_a = '0;
  logic [7:0]       cmd_b = '0;
  logic [3:0]       cmd_sel = '0;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_sel;
  logic [8:0]       alu_result;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [8:0]       rsp_result;
  logic [3:0]       rsp_sel;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];
  int accepted = 0;

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (s)
      ALU_ADD:  return {1'b0, a} + {1'b0, b};
      ALU_SUB:  return {1'b0, a} - {1'b0, b};
      ALU_MUL:  return p[8:0];
      ALU_DIV:  return (b == 8'd0) ? 9'd0 : {1'b0, a / b};
      ALU_SHL:  return {a, 1'b0};
      ALU_SHR:  return {2'b00, a[7:1]};
      ALU_ROL:  return {1'b0, a[6:0], a[7]};
      ALU_ROR:  return {1'b0, a[0], a[7:1]};
      ALU_AND:  return {1'b0, a & b};
      ALU_OR:   return {1'b0, a | b};
      ALU_XOR:  return {1'b0, a ^ b};
      ALU_NOR:  return {1'b0, ~(a | b)};
      ALU_NAND: return {1'b0, ~(a & b)};
      ALU_XNOR: return {1'b0, ~(a ^ b)};
      ALU_GT:   return {8'd0, a > b};
      ALU_EQ:   return {8'd0, a == b};
      default:  return 9'd0;
    endcase
  endfunction

  // Combinational ALU seen by the sequencer.
  always_comb alu_result = alu_model(alu_a, alu_b, alu_sel);

  alu_cmd_sequencer #(
    .DEPTH(DEPTH),
    .SETTLE_CYCLES(SETTLE),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_sel(rsp_sel), .op_count(op_count)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic apply_reset();
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    accepted = 0;
  endtask

  // Offer one command at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    bit ok = 1'b0;
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(negedge clk);
      exp_q.push_back({s, alu_model(a, b, s)});
      accepted++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept: cmd_ready got 0 for 64 cycles, expected 1");
    end
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int n = 0; n < 32; n++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rsp_wait: rsp_valid got 0 for 32 cycles, expected 1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    checks++; if (op_count !== '0) begin errors++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
    checks++; if ({alu_a, alu_b, alu_sel} !== 20'd0) begin errors++; $display("FAIL reset_alu_regs: got %h expected 0", {alu_a, alu_b, alu_sel}); end
    checks++; if ({rsp_result, rsp_sel} !== 13'd0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", {rsp_result, rsp_sel}); end
    rst = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b expected 1", cmd_ready); end
  endtask

  task automatic test_single_add();
    apply_reset();
    send(8'd255, 8'd0, ALU_ADD);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %0b expected 0", rsp_valid); end
    checks++; if ({alu_a, alu_b, alu_sel} !== {8'd255, 8'd0, ALU_ADD}) begin errors++; $display("FAIL add_operands: got %h expected %h", {alu_a, alu_b, alu_sel}, {8'd255, 8'd0, ALU_ADD}); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_latency: rsp_valid got %0b expected 1", rsp_valid); end
    checks++; if (rsp_result !== 9'd255) begin errors++; $display("FAIL add_result: got %0d expected 255", rsp_result); end
    checks++; if (rsp_sel !== ALU_ADD) begin errors++; $display("FAIL add_sel: got %0d expected 0", rsp_sel); end
    checks++; if (op_count !== CNT_W'(1)) begin errors++; $display("FAIL add_op_count: got %0d expected 1", op_count); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    void'(exp_q.pop_front());
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_empty: rsp_valid got %0b expected 0", rsp_valid); end
    checks++; if (rsp_result !== 9'd255) begin errors++; $display("FAIL add_hold_last: got %0d expected 255", rsp_result); end
    checks++; if (alu_a !== 8'd255) begin errors++; $display("FAIL add_alu_hold: got %0d expected 255", alu_a); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] want [2];
    time t1;
    want[0] = 9'd255;
    want[1] = 9'h1FE;
    apply_reset();
    send(8'd240, 8'd15, ALU_ADD);
    t1 = $time;
    send(8'd255, 8'd255, ALU_ADD);
    checks++; if (($time - t1) !== 64'(20)) begin errors++; $display("FAIL b2b_throughput: got %0t expected 20 between accepts", $time - t1); end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      wait_valid();
      checks++; if (rsp_result !== want[i]) begin errors++; $display("FAIL b2b_result%0d: got %0d expected %0d", i, rsp_result, want[i]); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      void'(exp_q.pop_front());
    end
    checks++; if (op_count !== CNT_W'(2)) begin errors++; $display("FAIL b2b_op_count: got %0d expected 2", op_count); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: rsp_valid got %0b expected 0", rsp_valid); end
  endtask

  task automatic test_full();
    logic [12:0] e;
    logic [7:0] a5, b5;
    logic [3:0] s5;
    apply_reset();
    for (int i = 0; i < 4; i++) send(8'($urandom), 8'($urandom), 4'($urandom));
    a5 = 8'($urandom); b5 = 8'($urandom); s5 = 4'($urandom);
    cmd_a = a5; cmd_b = b5; cmd_sel = s5; cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low%0d: got %0b expected 0", i, cmd_ready); end
    end
    e = exp_q[0];
    checks++; if ({rsp_sel, rsp_result} !== e) begin errors++; $display("FAIL full_head: got %h expected %h", {rsp_sel, rsp_result}, e); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    void'(exp_q.pop_front());
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise: got %0b expected 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_q.push_back({s5, alu_model(a5, b5, s5)});
    accepted++;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wait_valid();
      e = exp_q.pop_front();
      checks++; if ({rsp_sel, rsp_result} !== e) begin errors++; $display("FAIL full_drain%0d: got %h expected %h", i, {rsp_sel, rsp_result}, e); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL full_drained: rsp_valid got %0b expected 0", rsp_valid); end
    checks++; if (op_count !== CNT_W'(accepted)) begin errors++; $display("FAIL full_op_count: got %0d expected %0d", op_count, CNT_W'(accepted)); end
  endtask

  task automatic test_push_pop_same();
    logic [12:0] e;
    apply_reset();
    for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 4'($urandom));
    repeat (2) @(negedge clk);
    send(8'($urandom), 8'($urandom), 4'($urandom));
    rsp_ready = 1'b1;
    e = exp_q[0];
    checks++; if ({rsp_sel, rsp_result} !== e) begin errors++; $display("FAIL pp_head: got %h expected %h", {rsp_sel, rsp_result}, e); end
    @(negedge clk);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      checks++; if ({rsp_valid, rsp_sel, rsp_result} !== {1'b1, e}) begin errors++; $display("FAIL pp_entry%0d: got %h expected %h", i, {rsp_valid, rsp_sel, rsp_result}, {1'b1, e}); end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pp_no_extra: rsp_valid got %0b expected 0", rsp_valid); end
    checks++; if (op_count !== CNT_W'(4)) begin errors++; $display("FAIL pp_op_count: got %0d expected 4", op_count); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send(8'($urandom), 8'($urandom), 4'($urandom));
    repeat (2) @(negedge clk);
    send(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 4'($urandom_range(1, 15)));
    rst = 1'b1;
    #1;
    checks++; if ({alu_a, alu_b, alu_sel} !== 20'd0) begin errors++; $display("FAIL mid_alu_regs: got %h expected 0", {alu_a, alu_b, alu_sel}); end
    checks++; if ({rsp_valid, rsp_result, rsp_sel} !== 14'd0) begin errors++; $display("FAIL mid_rsp: got %h expected 0", {rsp_valid, rsp_result, rsp_sel}); end
    checks++; if (op_count !== '0) begin errors++; $display("FAIL mid_op_count: got %0d expected 0", op_count); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    accepted = 0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0b expected 1", cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp%0d: got %0b expected 0", i, rsp_valid); end
    end
    checks++; if (op_count !== '0) begin errors++; $display("FAIL mid_count_after: got %0d expected 0", op_count); end
  endtask

  task automatic test_wrap();
    logic [12:0] e;
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(8'($urandom), 8'($urandom), 4'($urandom));
      wait_valid();
      e = exp_q.pop_front();
      checks++; if ({rsp_sel, rsp_result} !== e) begin errors++; $display("FAIL wrap_op%0d: got %h expected %h", i, {rsp_sel, rsp_result}, e); end
      @(negedge clk);
      if (i == 15) begin
        checks++; if (op_count !== '0) begin errors++; $display("FAIL wrap_at16: got %0d expected 0", op_count); end
      end
    end
    rsp_ready = 1'b0;
    checks++; if (op_count !== CNT_W'(1)) begin errors++; $display("FAIL wrap_17: got %0d expected 1", op_count); end
  endtask

  task automatic test_random();
    int got = 0;
    logic [12:0] e;
    apply_reset();
    fork
      begin
        for (int i = 0; i < 40; i++) send(8'($urandom), 8'($urandom), 4'($urandom));
      end
      begin
        for (int c = 0; c < 3000 && got < 40; c++) begin
          rsp_ready = 1'($urandom_range(0, 1));
          if (rsp_valid && rsp_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
            checks++; if ({rsp_sel, rsp_result} !== e) begin errors++; $display("FAIL rand_op%0d: got %h expected %h", got, {rsp_sel, rsp_result}, e); end
            got++;
          end
          @(negedge clk);
        end
      end
    join
    rsp_ready = 1'b0;
    checks++; if (got !== 40) begin errors++; $display("FAIL rand_count: got %0d responses expected 40", got); end
    checks++; if (op_count !== CNT_W'(accepted)) begin errors++; $display("FAIL rand_op_count: got %0d expected %0d", op_count, CNT_W'(accepted)); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_full();
    test_push_pop_same();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
